// File: rtl/validator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : validator_pkg
//  Description : Shared types and constants for the validator ingress
//                scheduler: transaction width, transaction type, scheduler
//                state encoding and default credit depth (validator FIFO
//                depth).
//  Revision    : 1.0 - initial release
// ============================================================================
package validator_pkg;

    localparam int TRANS_W = 128;
    localparam int CREDITS = 16;

    typedef logic [TRANS_W-1:0] trans_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } sched_state_e;

endpackage : validator_pkg
`default_nettype wire

// File: rtl/validator_ingress_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin pick. Searches req_i
//                starting at ptr_i and wrapping modulo N; the first set bit
//                wins.
//  Ports       : req_i   - request vector
//                ptr_i   - search start position (0..N-1)
//                grant_o - one-hot winner (all zero when no request)
//                idx_o   - encoded winner index (0 when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] pos;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/validator_ingress_sched.sv
`default_nettype none
// ============================================================================
//  Module      : validator_ingress_sched
//  Description : Round-robin scheduler sharing the validator ingress between
//                NUM_SRC sources. The validator FIFO has no full flag, so
//                free slots are tracked with a credit counter; a transaction
//                is only issued while a credit is available. A pause/drain
//                sequence lets software quiesce the pipeline.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                src_valid/data  - per-source requests (source i at
//                                  bits [i*TRANS_W +: TRANS_W])
//                src_ready       - per-source accept (combinational, one-hot)
//                o_valid/o_transaction/o_src_id - registered output, lat 1
//                i_pop, i_drop   - credit return pulses
//                i_pause         - quiesce request (level)
//                o_drained       - pipeline empty and paused
//                o_credits       - current credit count
//                o_credit_err    - sticky credit overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module validator_ingress_sched #(
    parameter int NUM_SRC = 4,
    parameter int TRANS_W = validator_pkg::TRANS_W,
    parameter int CREDITS = validator_pkg::CREDITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*TRANS_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         o_valid,
    output logic [TRANS_W-1:0]           o_transaction,
    output logic [$clog2(NUM_SRC)-1:0]   o_src_id,
    input  logic                         i_pop,
    input  logic                         i_drop,
    input  logic                         i_pause,
    output logic                         o_drained,
    output logic [$clog2(CREDITS+1)-1:0] o_credits,
    output logic                         o_credit_err
);

    import validator_pkg::*;

    localparam int IW  = $clog2(NUM_SRC);
    localparam int CW  = $clog2(CREDITS + 1);
    localparam int CW1 = CW + 1;

    sched_state_e       state_q;
    logic               drained_q;
    logic [CW-1:0]      credits_q;
    logic [CW-1:0]      credits_d;
    logic               credit_err_q;
    logic               cred_over;
    logic [CW1-1:0]     cred_sum;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      ptr_d;
    logic               valid_q;
    logic [TRANS_W-1:0] trans_q;
    logic [IW-1:0]      src_id_q;

    logic [NUM_SRC-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               grant_en;
    logic               hs;

    rr_arbiter #(
        .N       (NUM_SRC)
    ) u_arb (
        .req_i   (src_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // A pause request blocks grants in the same cycle it is seen, so nothing
    // new enters the pipeline once draining has been asked for.
    assign grant_en  = (state_q == RUN) && !i_pause && (credits_q != '0);
    assign src_ready = grant_en ? arb_grant : '0;
    assign hs        = grant_en && (|src_valid);
    assign ptr_d     = (arb_idx == IW'(NUM_SRC - 1)) ? '0 : arb_idx + IW'(1);

    // One extra bit so a return on top of a full count is detectable before
    // saturation. Grants only happen at credits > 0, so no underflow.
    always_comb begin
        cred_sum  = {1'b0, credits_q} + {{CW{1'b0}}, i_pop}
                  + {{CW{1'b0}}, i_drop} - {{CW{1'b0}}, hs};
        cred_over = 1'b0;
        credits_d = cred_sum[CW-1:0];
        if (cred_sum > CW1'(CREDITS)) begin
            cred_over = 1'b1;
            credits_d = CW'(CREDITS);
        end
    end

    // Scheduler FSM with registered drained flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            drained_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (i_pause) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Pause dropping mid-drain is intentionally ignored; the
                    // pipeline still empties fully before resuming.
                    if (credits_q == CW'(CREDITS)) begin
                        state_q   <= DRAINED;
                        drained_q <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!i_pause) begin
                        state_q   <= RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    // Credit counter, round-robin pointer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q    <= CW'(CREDITS);
            credit_err_q <= 1'b0;
            ptr_q        <= '0;
            valid_q      <= 1'b0;
            trans_q      <= '0;
            src_id_q     <= '0;
        end else begin
            credits_q <= credits_d;
            if (cred_over) begin
                credit_err_q <= 1'b1;
            end
            valid_q <= hs;
            if (hs) begin
                trans_q  <= src_data[arb_idx*TRANS_W +: TRANS_W];
                src_id_q <= arb_idx;
                ptr_q    <= ptr_d;
            end
        end
    end

    assign o_valid       = valid_q;
    assign o_transaction = trans_q;
    assign o_src_id      = src_id_q;
    assign o_drained     = drained_q;
    assign o_credits     = credits_q;
    assign o_credit_err  = credit_err_q;

endmodule : validator_ingress_sched
`default_nettype wire

// File: doc/validator_ingress_sched.md
Name: validator_ingress_sched

Overview:
Round-robin scheduler that shares the single validator ingress (filter -> FIFO -> transaction validator -> hash) between NUM_SRC transaction sources. The validator FIFO has no full flag, so the block tracks free FIFO slots with a credit counter. It issues a transaction only when a credit is available. It also provides a pause/drain sequence so software can quiesce the pipeline.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
TRANS_W, 128, transaction width in bits
CREDITS, 16, FIFO depth; initial and maximum credit count

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  per-source request
src_data  in  NUM_SRC*TRANS_W  per-source transaction; source i occupies bits [i*TRANS_W +: TRANS_W]
src_ready  out  NUM_SRC  per-source accept; combinational, at most one bit high
o_valid  out  1  transaction strobe to the validator i_valid
o_transaction  out  TRANS_W  transaction to the validator
o_src_id  out  $clog2(NUM_SRC)  source index of o_transaction
i_pop  in  1  FIFO read pulse (transaction validator ack); returns one credit
i_drop  in  1  difficulty-filter reject pulse; returns one credit
i_pause  in  1  level; request quiesce
o_drained  out  1  high in DRAINED state
o_credits  out  $clog2(CREDITS+1)  current credit count
o_credit_err  out  1  sticky; set when a return would exceed CREDITS

Behaviour:
- Reset values: o_valid=0, o_transaction=0, o_src_id=0, o_drained=0, o_credits=CREDITS, o_credit_err=0, RR pointer=0, state=RUN.
- FSM has three states:
  - RUN: grants are allowed. If i_pause=1, go to DRAIN next cycle; no grant is issued in that cycle.
  - DRAIN: no grants. When credits==CREDITS, go to DRAINED.
  - DRAINED: o_drained=1, no grants. When i_pause=0, go to RUN.
  - If i_pause drops while in DRAIN, finish draining to DRAINED, then go to RUN in the following cycle.
- Arbitration:
  - grant_en = (state==RUN) && !i_pause && (credits>0).
  - The winner is the first src_valid bit found at or after the RR pointer, wrapping modulo NUM_SRC.
  - src_ready[winner] = grant_en. All other src_ready bits are 0.
  - A handshake (src_valid[i] && src_ready[i]) sets the pointer to (i+1) mod NUM_SRC. Without a handshake the pointer holds.
- Output timing:
  - Output is registered with latency 1: a handshake in cycle N gives o_valid=1 in cycle N+1, with o_transaction and o_src_id from the accepted source.
  - o_valid is a single-cycle pulse per accepted transaction. Back-to-back grants give consecutive pulses.
  - o_transaction holds its last value when o_valid=0.
- Credits:
  - credits_next = credits - grant + i_pop + i_drop, where each term is 0 or 1. Grant, pop and drop in the same cycle are all counted.
  - If the computed value exceeds CREDITS, saturate at CREDITS and set o_credit_err. o_credit_err clears only on rst.
  - A grant is never issued at credits==0, so credits never underflow.
- Sources:
  - A source must hold src_valid and src_data stable until accepted.
  - The scheduler never drops a request.
- Reset mid-operation: a pending o_valid is cancelled, credits return to CREDITS, and the in-flight FIFO contents are the responsibility of the system reset.

Decomposition:
- validator_pkg holds:
  - TRANS_W=128 constant.
  - trans_t typedef (logic [TRANS_W-1:0]).
  - sched_state_e enum {RUN, DRAIN, DRAINED}.
  - Default CREDITS=16, matching the FIFO depth.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: req, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The FSM, credit counter and output register stay in validator_ingress_sched.

Test Plan:
1. Single source: after reset, src_valid=0001 for 3 cycles -> src_ready[0]=1 for 3 cycles; o_valid pulses on cycles 2-4 with src_id=0; o_credits falls 16->13.
2. Fairness: all four src_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and o_src_id follows with 1-cycle lag.
3. Credit exhaustion: no i_pop for 20 requests -> exactly 16 grants, src_ready=0 at credits=0. One i_pop pulse -> exactly one further grant.
4. Simultaneous events: at credits=5 assert grant+i_pop+i_drop in one cycle -> credits=6. At credits=16 inject an extra i_pop -> credits stay 16 and o_credit_err=1.
5. Drain: with 3 transactions in flight assert i_pause -> no grants from the next cycle; after 3 i_pop pulses o_drained=1. Deassert i_pause -> o_drained=0 and grants resume from the saved RR pointer.
6. Reset mid-stream: assert rst in the cycle after a grant -> o_valid=0, o_credits=16, RR pointer=0 in the next cycle.
